// File: rtl/mem_access.sv
// Memory-access pipeline stage: drives the data-memory req/ack port, extends load data, registers the writeback result.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses are abandoned with a bus_err pulse.
module mem_access #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2E,
    input  logic        write_regE,
    input  logic [2:0]  info_loadE,
    input  logic [1:0]  info_storeE,
    input  logic [4:0]  dstreg_addrE,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        stall_mem,
    output logic [31:0] forward_data_writemem,
    output logic        write_regM,
    output logic [4:0]  dstreg_addrM,
    output logic [31:0] wb_data,
    output logic        bus_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        is_store;
    logic        is_load;
    logic        trap;
    logic        access;
    logic        timeout;
    logic [1:0]  lane;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    assign lane     = alu_result[1:0];
    assign is_store = |info_storeE;
    // A store wins over a load presented in the same cycle.
    assign is_load  = !is_store && (info_loadE >= 3'd1) && (info_loadE <= 3'd5);

`ifdef MEM_MISALIGN_TRAP_EN
    logic half_access;
    logic word_access;
    assign half_access = (info_storeE == 2'd2) || (is_load && (info_loadE == 3'd2 || info_loadE == 3'd5));
    assign word_access = (info_storeE == 2'd3) || (is_load && info_loadE == 3'd3);
    assign trap        = (half_access && lane[0]) || (word_access && lane != 2'd0);
`else
    assign trap = 1'b0;
`endif

    assign access  = (is_store || is_load) && !trap;
    // The timeout cycle itself retires the instruction, so it must not stall.
    assign timeout = (state == S_WAIT) && access && !dmem_ack && (cnt == CNT_LAST);

    assign dmem_req              = access && !rst;
    assign stall_mem             = dmem_req && !dmem_ack && !timeout;
    assign dmem_we               = is_store;
    assign dmem_addr             = {alu_result[31:2], 2'b00};
    assign forward_data_writemem = alu_result;

    always_comb begin
        dmem_be    = is_load ? 4'b1111 : 4'b0000;
        dmem_wdata = rs2E;
        case (info_storeE)
            2'd1: begin
                dmem_be    = 4'b0001 << lane;
                dmem_wdata = {4{rs2E[7:0]}};
            end
            2'd2: begin
                dmem_be    = 4'b0011 << lane;
                dmem_wdata = {2{rs2E[15:0]}};
            end
            2'd3: begin
                dmem_be    = 4'b1111;
                dmem_wdata = rs2E;
            end
            default: ;
        endcase
    end

    assign rd_byte = dmem_rdata[{lane, 3'b000} +: 8];
    assign rd_half = dmem_rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        case (info_loadE)
            3'd1:    load_data = {{24{rd_byte[7]}}, rd_byte};
            3'd2:    load_data = {{16{rd_half[15]}}, rd_half};
            3'd4:    load_data = {24'b0, rd_byte};
            3'd5:    load_data = {16'b0, rd_half};
            default: load_data = dmem_rdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access && !dmem_ack) begin
                        state <= S_WAIT;
                        cnt   <= 8'd0;
                    end
                end
                S_WAIT: begin
                    if (!access || dmem_ack || timeout) state <= S_IDLE;
                    else                                cnt   <= cnt + 8'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_regM   <= 1'b0;
            dstreg_addrM <= 5'd0;
            wb_data      <= 32'd0;
            bus_err      <= 1'b0;
        end else begin
            bus_err <= timeout || trap;
            if (stall_mem) begin
                write_regM <= 1'b0;
            end else begin
                write_regM   <= write_regE && !is_store && !timeout && !trap;
                dstreg_addrM <= dstreg_addrE;
                wb_data      <= is_load ? load_data : alu_result;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed accesses with literal expectations plus a per-cycle behavioural model.
// Honours MEM_MISALIGN_TRAP_EN when the bench is compiled with it.
module tb_mem_access;

    localparam int WM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_result = '0;
    logic [31:0] rs2E = '0;
    logic        write_regE = 1'b0;
    logic [2:0]  info_loadE = '0;
    logic [1:0]  info_storeE = '0;
    logic [4:0]  dstreg_addrE = '0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        stall_mem;
    logic [31:0] forward_data_writemem;
    logic        write_regM;
    logic [4:0]  dstreg_addrM;
    logic [31:0] wb_data;
    logic        bus_err;

    int tests = 0;
    int fails = 0;

    mem_access #(.WAIT_MAX(WM)) dut (
        .clk(clk), .rst(rst), .alu_result(alu_result), .rs2E(rs2E), .write_regE(write_regE),
        .info_loadE(info_loadE), .info_storeE(info_storeE), .dstreg_addrE(dstreg_addrE),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .stall_mem(stall_mem),
        .forward_data_writemem(forward_data_writemem), .write_regM(write_regM),
        .dstreg_addrM(dstreg_addrM), .wb_data(wb_data), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model, checked every falling edge ----------------
    logic        m_wreg = 1'b0;
    logic [4:0]  m_dst = '0;
    logic [31:0] m_wb = '0;
    logic        m_err = 1'b0;
    int          m_waited = 0;
    int          m_n;
    int          m_a;
    logic        m_st, m_ld, m_mis, m_req, m_tmo, m_stl;
    logic [31:0] m_mask, m_raw, m_val, m_wd;
    logic [3:0]  m_be;
    int          m_tmp;

    always @(negedge clk) begin
        if (rst) begin
            m_wreg = 1'b0; m_dst = '0; m_wb = '0; m_err = 1'b0; m_waited = 0;
        end
        check("model_write_regM", write_regM, m_wreg);
        check("model_dstreg_addrM", dstreg_addrM, m_dst);
        check("model_wb_data", wb_data, m_wb);
        check("model_bus_err", bus_err, m_err);
        check("model_forward", forward_data_writemem, alu_result);
        if (rst) begin
            check("model_req_in_reset", dmem_req, 0);
            check("model_stall_in_reset", stall_mem, 0);
        end else begin
            m_a  = int'(alu_result[1:0]);
            m_st = (info_storeE != 0);
            m_ld = !m_st && info_loadE >= 1 && info_loadE <= 5;
            if (m_st)                                m_n = (info_storeE == 1) ? 1 : (info_storeE == 2) ? 2 : 4;
            else if (info_loadE == 1 || info_loadE == 4) m_n = 1;
            else if (info_loadE == 2 || info_loadE == 5) m_n = 2;
            else                                     m_n = 4;
            m_mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            m_mis = (m_st || m_ld) && ((m_n == 2 && m_a % 2 != 0) || (m_n == 4 && m_a != 0));
`endif
            m_req = (m_st || m_ld) && !m_mis;
            m_tmo = m_req && !dmem_ack && m_waited >= WM;
            m_stl = m_req && !dmem_ack && !m_tmo;
            check("model_req", dmem_req, m_req);
            check("model_stall", stall_mem, m_stl);
            if (m_req) begin
                check("model_addr", dmem_addr, alu_result - m_a);
                check("model_we", dmem_we, m_st);
                if (m_st && m_n != 4) begin
                    m_tmp = ((1 << m_n) - 1) << m_a;
                    m_be  = m_tmp[3:0];
                end else begin
                    m_be = 4'hF;
                end
                check("model_be", dmem_be, m_be);
                if (m_st) begin
                    for (int i = 0; i < 4; i++) m_wd[8*i +: 8] = rs2E[8*(i % m_n) +: 8];
                    check("model_wdata", dmem_wdata, m_wd);
                end
            end
            // load value from the lane arithmetic of the access
            m_mask = (m_n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * m_n)) - 1;
            m_raw  = (m_n == 1) ? dmem_rdata >> (8 * m_a) : (m_n == 2) ? dmem_rdata >> (16 * (m_a / 2)) : dmem_rdata;
            m_val  = m_raw & m_mask;
            if ((info_loadE == 1 || info_loadE == 2) && m_val[8*m_n-1]) m_val = m_val | ~m_mask;

            m_err = m_tmo || m_mis;
            if (m_stl) begin
                m_wreg = 1'b0;
                m_waited++;
            end else begin
                m_wreg   = write_regE && !m_st && !m_tmo && !m_mis;
                m_dst    = dstreg_addrE;
                m_wb     = m_ld ? m_val : alu_result;
                m_waited = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic        snap_req, snap_we;
    logic [3:0]  snap_be;
    logic [31:0] snap_wd, snap_addr;

    // Called at posedge+1; returns at posedge+1 after the edge that retired the access.
    task automatic do_access(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] addr,
                             input logic [31:0] rs2, input logic wr, input logic [4:0] dst,
                             input logic [31:0] rdata, input int ack_after, output int stalls);
        logic done;
        logic s;
        info_loadE = ld; info_storeE = st; alu_result = addr; rs2E = rs2;
        write_regE = wr; dstreg_addrE = dst; dmem_rdata = rdata;
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            dmem_ack = (c == ack_after);
            #3;
            if (c == 0) begin
                snap_req = dmem_req; snap_we = dmem_we; snap_be = dmem_be;
                snap_wd = dmem_wdata; snap_addr = dmem_addr;
            end
            s = stall_mem;
            if (s) stalls++;
            else   done = 1'b1;
            @(posedge clk); #1;
        end
        check("access_retired_in_budget", done, 1);
        info_loadE = 0; info_storeE = 0; dmem_ack = 1'b0; write_regE = 1'b0;
    endtask

    int n_stall;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #3;
        check("reset_write_regM", write_regM, 0);
        check("reset_wb_data", wb_data, 0);
        check("reset_dstreg", dstreg_addrM, 0);
        check("reset_bus_err", bus_err, 0);
        check("reset_req", dmem_req, 0);
        @(posedge clk); #1;

        // LW, zero-wait
        do_access(3'd3, 2'd0, 32'h100, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF, 0, n_stall);
        check("lw_no_stall", n_stall, 0);
        check("lw_req", snap_req, 1);
        check("lw_addr", snap_addr, 32'h100);
        check("lw_be", snap_be, 4'hF);
        check("lw_wb", wb_data, 32'hDEAD_BEEF);
        check("lw_wreg", write_regM, 1);
        check("lw_dst", dstreg_addrM, 5);

        do_access(3'd1, 2'd0, 32'h103, 32'h0, 1'b1, 5'd6, 32'h80FF_FFFF, 0, n_stall);
        check("lb_sign", wb_data, 32'hFFFF_FF80);
        do_access(3'd4, 2'd0, 32'h103, 32'h0, 1'b1, 5'd6, 32'h80FF_FFFF, 0, n_stall);
        check("lbu_zero", wb_data, 32'h0000_0080);
        do_access(3'd2, 2'd0, 32'h102, 32'h0, 1'b1, 5'd7, 32'h8001_1234, 1, n_stall);
        check("lh_sign", wb_data, 32'hFFFF_8001);
        check("lh_one_stall", n_stall, 1);
        do_access(3'd5, 2'd0, 32'h100, 32'h0, 1'b1, 5'd7, 32'h8001_9234, 0, n_stall);
        check("lhu_zero", wb_data, 32'h0000_9234);

        // SH with three wait cycles
        do_access(3'd0, 2'd2, 32'h202, 32'h1234_ABCD, 1'b1, 5'd8, 32'h0, 3, n_stall);
        check("sh_be", snap_be, 4'b1100);
        check("sh_wdata", snap_wd, 32'hABCD_ABCD);
        check("sh_addr", snap_addr, 32'h200);
        check("sh_we", snap_we, 1);
        check("sh_stall_cycles", n_stall, 3);
        check("sh_no_regwrite", write_regM, 0);

        do_access(3'd0, 2'd1, 32'h201, 32'h0000_00EF, 1'b1, 5'd9, 32'h0, 0, n_stall);
        check("sb_be", snap_be, 4'b0010);
        check("sb_wdata", snap_wd, 32'hEFEF_EFEF);
        check("sb_no_regwrite", write_regM, 0);

        // load and store together: the store wins
        do_access(3'd3, 2'd3, 32'h300, 32'h0102_0304, 1'b1, 5'd10, 32'h5555_5555, 0, n_stall);
        check("both_we", snap_we, 1);
        check("both_wdata", snap_wd, 32'h0102_0304);
        check("both_no_regwrite", write_regM, 0);

        // plain ALU op with a stray ack and an undefined load code
        info_loadE = 3'd6; alu_result = 32'h55AA; write_regE = 1'b1; dstreg_addrE = 5'd11; dmem_ack = 1'b1;
        #3;
        check("alu_no_req", dmem_req, 0);
        check("alu_no_stall", stall_mem, 0);
        @(posedge clk); #1;
        check("alu_wb", wb_data, 32'h55AA);
        check("alu_wreg", write_regM, 1);
        check("alu_dst", dstreg_addrM, 11);
        info_loadE = 0; write_regE = 1'b0; dmem_ack = 1'b0;

        // timeout after WAIT_MAX wait cycles
        do_access(3'd3, 2'd0, 32'h400, 32'h0, 1'b1, 5'd12, 32'h0, -1, n_stall);
        check("tmo_stall_cycles", n_stall, WM);
        check("tmo_bus_err", bus_err, 1);
        check("tmo_no_regwrite", write_regM, 0);
        @(posedge clk); #1;
        check("tmo_err_one_cycle", bus_err, 0);

        // reset during the second wait cycle
        info_loadE = 3'd3; alu_result = 32'h500; write_regE = 1'b1; dstreg_addrE = 5'd13;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_req_drop", dmem_req, 0);
        check("rst_wreg", write_regM, 0);
        check("rst_stall_drop", stall_mem, 0);
        info_loadE = 0; write_regE = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        do_access(3'd3, 2'd0, 32'h104, 32'h0, 1'b1, 5'd14, 32'h1122_3344, 0, n_stall);
        check("post_rst_wb", wb_data, 32'h1122_3344);
        check("post_rst_wreg", write_regM, 1);

`ifdef MEM_MISALIGN_TRAP_EN
        do_access(3'd3, 2'd0, 32'h101, 32'h0, 1'b1, 5'd15, 32'hCAFE_F00D, -1, n_stall);
        check("trap_no_req", snap_req, 0);
        check("trap_no_stall", n_stall, 0);
        check("trap_bus_err", bus_err, 1);
        check("trap_no_regwrite", write_regM, 0);
`else
        do_access(3'd3, 2'd0, 32'h101, 32'h0, 1'b1, 5'd15, 32'hCAFE_F00D, 0, n_stall);
        check("misalign_req", snap_req, 1);
        check("misalign_addr", snap_addr, 32'h100);
        check("misalign_wb", wb_data, 32'hCAFE_F00D);
        check("misalign_no_err", bus_err, 0);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
